// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: filtered clk/data deserialiser plus a byte FSM that folds E0/F0
// prefixes into one {toggle,pressed,ext,code} event per make/break and drops Pause/system bytes.
module ps2_key_decoder #(
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 50000
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [10:0] ps2_key,
    output logic        key_stb,
    output logic        frame_err
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [1:0] pin_raw;
    logic [1:0] pin_filt;
    assign pin_raw = {ps2_dat_in, ps2_clk_in};

    // Bit 0 is the PS/2 clock, bit 1 the data line; both get identical conditioning.
    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        logic          s1_q, s2_q, f_q, f_d;
        logic [FW-1:0] cnt_q, cnt_d;

        always_comb begin
            f_d   = f_q;
            cnt_d = '0;
            if (s2_q != f_q) begin
                if (cnt_q == FW'(FILT_LEN - 1)) begin
                    f_d = s2_q;
                end else begin
                    cnt_d = cnt_q + FW'(1);
                end
            end
        end

        always_ff @(posedge clk_sys) begin
            if (RESET) begin
                s1_q  <= 1'b1;
                s2_q  <= 1'b1;
                f_q   <= 1'b1;
                cnt_q <= '0;
            end else begin
                s1_q  <= pin_raw[gi];
                s2_q  <= s1_q;
                f_q   <= f_d;
                cnt_q <= cnt_d;
            end
        end

        assign pin_filt[gi] = f_q;
    end

    logic clk_prev_q;
    logic fall;
    logic dat;
    assign fall = clk_prev_q & ~pin_filt[0];
    assign dat  = pin_filt[1];

    logic [1:0]    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_q, to_d;
    logic          byte_ok_q, byte_ok_d;
    logic          frame_err_q, frame_err_d;
    logic          ext_q, ext_d;
    logic          rel_q, rel_d;
    logic [2:0]    skip_q, skip_d;
    logic [10:0]   ps2_key_q, ps2_key_d;
    logic          key_stb_q, key_stb_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        to_d        = '0;
        byte_ok_d   = 1'b0;
        frame_err_d = 1'b0;

        if (state_q != ST_IDLE) begin
            to_d = fall ? '0 : to_q + TW'(1);
        end

        if (state_q != ST_IDLE && !fall && to_q == TW'(TIMEOUT - 1)) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            bit_cnt_d   = 4'd0;
            to_d        = '0;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 4'd1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd8) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d  = dat;
                    bit_cnt_d = 4'd10;
                    state_d   = ST_STOP;
                end
                default: begin
                    // Odd parity over data+parity, and the stop bit must be high.
                    if ((^shift_q ^ parity_q) && dat) begin
                        byte_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d   = ST_IDLE;
                    bit_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        ext_d     = ext_q;
        rel_d     = rel_q;
        skip_d    = skip_q;
        ps2_key_d = ps2_key_q;
        key_stb_d = 1'b0;

        if (byte_ok_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (shift_q)
                    8'hE1: skip_d = 3'd7;
                    8'hE0: ext_d  = 1'b1;
                    8'hF0: rel_d  = 1'b1;
                    8'h00, 8'hAA, 8'hEE, 8'hFA,
                    8'hFC, 8'hFD, 8'hFE, 8'hFF: ;
                    default: begin
                        ps2_key_d = {~ps2_key_q[10], ~rel_q, ext_q, shift_q};
                        key_stb_d = 1'b1;
                        ext_d     = 1'b0;
                        rel_d     = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            clk_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            parity_q    <= 1'b0;
            to_q        <= '0;
            byte_ok_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            skip_q      <= 3'd0;
            ps2_key_q   <= 11'd0;
            key_stb_q   <= 1'b0;
        end else begin
            clk_prev_q  <= pin_filt[0];
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            to_q        <= to_d;
            byte_ok_q   <= byte_ok_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            rel_q       <= rel_d;
            skip_q      <= skip_d;
            ps2_key_q   <= ps2_key_d;
            key_stb_q   <= key_stb_d;
        end
    end

    assign ps2_key   = ps2_key_q;
    assign key_stb   = key_stb_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus queues expected events, a monitor checks them.
module tb_ps2_key_decoder;
    localparam int HALF = 30;
    localparam int GAP  = 80;
    localparam int TO   = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [10:0] ps2_key;
    logic        key_stb;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_err;
        logic [10:0] word;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ps2_key_decoder #(.FILT_LEN(8), .TIMEOUT(TO)) dut (
        .clk_sys   (clk),
        .RESET     (rst),
        .ps2_clk_in(ps2_clk),
        .ps2_dat_in(ps2_dat),
        .ps2_key   (ps2_key),
        .key_stb   (key_stb),
        .frame_err (frame_err)
    );

    // Monitor: every output pulse must match the head of the expectation queue.
    logic stb_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (key_stb || frame_err) begin
                exp_t e;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output key=%h stb=%b err=%b required=none", ps2_key, key_stb, frame_err);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err) begin
                        if (!frame_err || key_stb) begin
                            bad++;
                            $display("FAIL err_event stb=%b err=%b required err=1 stb=0", key_stb, frame_err);
                        end else
                            $display("event frame_err ok");
                    end else begin
                        if (!key_stb || frame_err || ps2_key !== e.word) begin
                            bad++;
                            $display("FAIL key_event key=%h stb=%b err=%b required key=%h", ps2_key, key_stb, frame_err, e.word);
                        end else
                            $display("event key=%h ok", ps2_key);
                    end
                end
            end
            if (key_stb) begin
                total++;
                if (stb_prev) begin
                    bad++;
                    $display("FAIL stb_width got=2+ cycles required=1");
                end
            end
        end
        stb_prev = key_stb && !rst;
    end

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end else
            $display("check %s = %h ok", name, got);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit good_par = 1'b1, input int nbits = 11);
        logic [10:0] fr;
        logic        par;
        par = good_par ? ~^b : ^b;
        fr  = {1'b1, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
        ps2_dat = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic exp_key(input logic [10:0] w);
        exp_t e;
        e.is_err = 1'b0;
        e.word   = w;
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        exp_t e;
        e.is_err = 1'b1;
        e.word   = 11'd0;
        exp_q.push_back(e);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_key", ps2_key, 11'h000);
        chk("reset_stb", {10'd0, key_stb}, 11'h000);
        chk("reset_err", {10'd0, frame_err}, 11'h000);
        repeat (20) @(posedge clk);

        exp_key(11'h61C); send(8'h1C);
        send(8'hF0); exp_key(11'h01C); send(8'h1C);
        send(8'hE0); exp_key(11'h775); send(8'h75);
        send(8'hE0); send(8'hF0); exp_key(11'h175); send(8'h75);

        exp_err(); send(8'h29, 1'b0);
        chk("bad_parity_hold", ps2_key, 11'h175);
        exp_key(11'h629); send(8'h29);

        exp_err(); send(8'h16, 1'b1, 5);
        repeat (TO + 500) @(posedge clk);
        exp_key(11'h216); send(8'h16);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (GAP) @(posedge clk);
        chk("glitch_hold", ps2_key, 11'h216);

        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        exp_key(11'h605); send(8'h05);
        chk("pause_low10", {1'b0, ps2_key[9:0]}, 11'h205);

        send(8'hFA); exp_key(11'h21C); send(8'h1C);
        exp_key(11'h61C); send(8'h1C);
        send(8'hF0); send(8'hE0); exp_key(11'h16B); send(8'h6B);

        send(8'h33, 1'b1, 4);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midreset_key", ps2_key, 11'h000);
        chk("midreset_stb", {10'd0, key_stb}, 11'h000);
        chk("midreset_err", {10'd0, frame_err}, 11'h000);
        repeat (20) @(posedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        exp_key(11'h61C); send(8'h1C);

        repeat (GAP) @(posedge clk);
        chk("queue_drained", 11'(exp_q.size()), 11'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
